// File: rtl/vga_pkg.sv
// Shared definitions for VGA scan-out blocks: default 800x600@72 timing,
// the pixel colour type, sync polarity constants and the per-pixel control word.
package vga_pkg;

   localparam int H_ACTIVE_DEF   = 800;
   localparam int H_FP_DEF       = 56;
   localparam int H_SYNC_DEF     = 120;
   localparam int H_BP_DEF       = 64;
   localparam int V_ACTIVE_DEF   = 600;
   localparam int V_FP_DEF       = 37;
   localparam int V_SYNC_DEF     = 6;
   localparam int V_BP_DEF       = 23;
   localparam int COLOR_W_DEF    = 12;

   localparam logic SYNC_ACTIVE_LOW  = 1'b0;
   localparam logic SYNC_ACTIVE_HIGH = 1'b1;

   typedef logic [COLOR_W_DEF-1:0] color_t;

   // Control bits that travel alongside the RAM read so they meet vdata.
   typedef struct packed {
      logic de;
      logic in_win;
      logic hs;
      logic vs;
      logic fs;
   } pix_ctl_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters with raw sync/active decode and the frame-origin strobe.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   output logic [11:0] hc,
   output logic [11:0] vc,
   output logic        active,
   output logic        hs_raw,
   output logic        vs_raw,
   output logic        origin
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   logic [11:0] hc_reg, hc_next;
   logic [11:0] vc_reg, vc_next;

   always_comb begin
      hc_next = hc_reg + 12'd1;
      vc_next = vc_reg;
      if (hc_reg == 12'(H_TOTAL - 1)) begin
         hc_next = 12'd0;
         vc_next = (vc_reg == 12'(V_TOTAL - 1)) ? 12'd0 : vc_reg + 12'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hc_reg <= 12'd0;
         vc_reg <= 12'd0;
      end else begin
         hc_reg <= hc_next;
         vc_reg <= vc_next;
      end
   end

   assign hc     = hc_reg;
   assign vc     = vc_reg;
   assign active = (hc_reg < 12'(H_ACTIVE)) && (vc_reg < 12'(V_ACTIVE));
   assign hs_raw = (hc_reg >= 12'(H_ACTIVE + H_FP)) && (hc_reg < 12'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_raw = (vc_reg >= 12'(V_ACTIVE + V_FP)) && (vc_reg < 12'(V_ACTIVE + V_FP + V_SYNC));
   assign origin = (hc_reg == 12'd0) && (vc_reg == 12'd0);

endmodule

// File: rtl/vga_window_ctrl.sv
// VGA scan-out of a frame-buffer window: per-frame window latch, RAM address
// generation, control delay line matched to the RAM latency, and colour select.
module vga_window_ctrl
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE   = H_ACTIVE_DEF,
   parameter int   H_FP       = H_FP_DEF,
   parameter int   H_SYNC     = H_SYNC_DEF,
   parameter int   H_BP       = H_BP_DEF,
   parameter int   V_ACTIVE   = V_ACTIVE_DEF,
   parameter int   V_FP       = V_FP_DEF,
   parameter int   V_SYNC     = V_SYNC_DEF,
   parameter int   V_BP       = V_BP_DEF,
   parameter int   WIN_W_LOG2 = 7,
   parameter int   WIN_H_LOG2 = 7,
   parameter int   SCALE_LOG2 = 0,
   parameter int   RD_LAT     = 1,
   parameter int   COLOR_W    = COLOR_W_DEF,
   parameter logic SYNC_POL   = SYNC_ACTIVE_LOW
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [10:0]                    win_x,
   input  logic [9:0]                     win_y,
   input  logic [COLOR_W-1:0]             bg_color,
   input  logic                           zero_sub_en,
   input  logic [COLOR_W-1:0]             zero_color,
   output logic [WIN_H_LOG2+WIN_W_LOG2-1:0] vaddr,
   input  logic [COLOR_W-1:0]             vdata,
   output logic [COLOR_W/3-1:0]           vga_r,
   output logic [COLOR_W/3-1:0]           vga_g,
   output logic [COLOR_W/3-1:0]           vga_b,
   output logic                           hs,
   output logic                           vs,
   output logic                           de,
   output logic                           frame_start
);

   localparam int          CW3   = COLOR_W / 3;
   localparam int          PIPE  = RD_LAT + 1;
   localparam logic [11:0] WW    = 12'(1 << (WIN_W_LOG2 + SCALE_LOG2));
   localparam logic [11:0] WH    = 12'(1 << (WIN_H_LOG2 + SCALE_LOG2));
   localparam int          AW    = WIN_H_LOG2 + WIN_W_LOG2;

   logic [11:0] hc, vc;
   logic        active, hs_raw, vs_raw, origin;

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk(clk), .rst(rst), .hc(hc), .vc(vc), .active(active),
      .hs_raw(hs_raw), .vs_raw(vs_raw), .origin(origin)
   );

   // The origin pixel already uses the freshly sampled position.
   logic [11:0] wx_reg, wy_reg, wx_eff, wy_eff;
   assign wx_eff = origin ? {1'b0, win_x} : wx_reg;
   assign wy_eff = origin ? {2'b0, win_y} : wy_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wx_reg <= 12'd0;
         wy_reg <= 12'd0;
      end else if (origin) begin
         wx_reg <= wx_eff;
         wy_reg <= wy_eff;
      end
   end

   logic                  in_win;
   logic [11:0]           dx, dy;
   logic [WIN_W_LOG2-1:0] col;
   logic [WIN_H_LOG2-1:0] row;
   logic [AW-1:0]         vaddr_reg, vaddr_next;
   pix_ctl_t              ctl_next;

   assign in_win = active && (hc >= wx_eff) && (hc < wx_eff + WW)
                          && (vc >= wy_eff) && (vc < wy_eff + WH);
   assign dx = hc - wx_eff;
   assign dy = vc - wy_eff;
   assign col = WIN_W_LOG2'(dx >> SCALE_LOG2);
   assign row = WIN_H_LOG2'(dy >> SCALE_LOG2);
   assign vaddr_next = in_win ? {row, col} : '0;

   always_comb begin
      ctl_next        = '0;
      ctl_next.de     = active;
      ctl_next.in_win = in_win;
      ctl_next.hs     = hs_raw;
      ctl_next.vs     = vs_raw;
      ctl_next.fs     = origin;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vaddr_reg <= '0;
      else     vaddr_reg <= vaddr_next;
   end
   assign vaddr = vaddr_reg;

   // Stage 0 is registered alongside vaddr; the remaining RD_LAT stages cover the RAM.
   pix_ctl_t ctl_pipe_reg [PIPE];
   generate
      for (genvar gi = 0; gi < PIPE; gi++) begin : g_ctl_pipe
         always_ff @(posedge clk or posedge rst) begin
            if (rst)          ctl_pipe_reg[gi] <= '0;
            else if (gi == 0) ctl_pipe_reg[gi] <= ctl_next;
            else              ctl_pipe_reg[gi] <= ctl_pipe_reg[(gi == 0) ? 0 : gi - 1];
         end
      end
   endgenerate

   pix_ctl_t             ctl_out;
   logic [COLOR_W-1:0]   rgb_reg, rgb_next;
   logic                 hs_reg, vs_reg, de_reg, fs_reg;

   assign ctl_out = ctl_pipe_reg[PIPE-1];

   always_comb begin
      rgb_next = '0;
      if (!ctl_out.de)                        rgb_next = '0;
      else if (!ctl_out.in_win)               rgb_next = bg_color;
      else if (zero_sub_en && vdata == '0)    rgb_next = zero_color;
      else                                    rgb_next = vdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb_reg <= '0;
         hs_reg  <= ~SYNC_POL;
         vs_reg  <= ~SYNC_POL;
         de_reg  <= 1'b0;
         fs_reg  <= 1'b0;
      end else begin
         rgb_reg <= rgb_next;
         hs_reg  <= ctl_out.hs ? SYNC_POL : ~SYNC_POL;
         vs_reg  <= ctl_out.vs ? SYNC_POL : ~SYNC_POL;
         de_reg  <= ctl_out.de;
         fs_reg  <= ctl_out.fs;
      end
   end

   assign vga_r       = rgb_reg[COLOR_W-1 -: CW3];
   assign vga_g       = rgb_reg[COLOR_W-CW3-1 -: CW3];
   assign vga_b       = rgb_reg[CW3-1:0];
   assign hs          = hs_reg;
   assign vs          = vs_reg;
   assign de          = de_reg;
   assign frame_start = fs_reg;

endmodule

// File: doc/vga_window_ctrl.md
# vga_window_ctrl

Parametrised VGA scan-out controller that generates sync timing and scans a frame-buffer window onto an arbitrary-resolution active area. The window has runtime position, power-of-two pixel replication and configurable colours. It sits between the display RAM (synchronous read, fixed latency) and the board VGA pins. It supersedes the fixed 800x600, 128x128-centred display block.

## Interface
- H_ACTIVE, 800: active pixels per line
- H_FP / H_SYNC / H_BP, 56 / 120 / 64: horizontal front porch, sync and back porch, in clocks
- V_ACTIVE, 600: active lines
- V_FP / V_SYNC / V_BP, 37 / 6 / 23: vertical front porch, sync and back porch, in lines
- WIN_W_LOG2 / WIN_H_LOG2, 7 / 7: window source size, 2^n pixels
- SCALE_LOG2, 0: each source pixel is shown as a 2^n x 2^n block
- RD_LAT, 1: display-RAM read latency in clocks (≥1)
- COLOR_W, 12: RGB width, split equally into R/G/B
- SYNC_POL, 0: sync active level (0 = active-low)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- win_x  in  11  window left edge, in active-area pixels
- win_y  in  10  window top edge, in active lines
- bg_color  in  COLOR_W  colour outside the window
- zero_sub_en  in  1  substitute zero_color when RAM data == 0
- zero_color  in  COLOR_W  substitute colour
- vaddr  out  WIN_H_LOG2+WIN_W_LOG2  RAM address {row, col}
- vdata  in  COLOR_W  RAM read data, valid RD_LAT clocks after vaddr
- vga_r / vga_g / vga_b  out  COLOR_W/3 each  pixel colour
- hs, vs  out  1  syncs
- de  out  1  active-video flag
- frame_start  out  1  one-clock pulse on the first active pixel of each frame

## Operation
- Counters: hc 0..H_TOTAL-1, vc 0..V_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1040 at defaults) and V_TOTAL likewise (666).
- Line order is active, FP, sync, BP. vc increments when hc wraps. Both counters wrap to 0 together at (H_TOTAL-1, V_TOTAL-1).
- Raw sync asserted for H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC, and likewise for vertical. Output level = SYNC_POL when asserted, otherwise ~SYNC_POL.
- Window registers wx/wy are loaded from win_x/win_y only when hc==0 and vc==0, so there is no tearing mid-frame.
- Window extent: WW = 2^(WIN_W_LOG2+SCALE_LOG2), WH analogous.
- in_win = active and wx ≤ hc < wx+WW and wy ≤ vc < wy+WH. Compare in 12-bit arithmetic so wx+WW never wraps.
- Portions of the window beyond the active area are clipped.
- Address: col = (hc-wx)>>SCALE_LOG2 and row = (vc-wy)>>SCALE_LOG2 when in_win. Otherwise vaddr = 0.
- Colour select at the output stage, in priority order:
  - not de: 0
  - not in_win: bg_color
  - zero_sub_en and vdata==0: zero_color
  - otherwise: vdata

## Timing
- Stage 0 is the counters. vaddr is registered from the stage-0 values.
- de, in_win, raw hs/vs and frame_start are delayed through a shift pipeline so they line up with vdata.
- Colour, hs, vs, de and frame_start are registered together. Total latency from counter to pins is RD_LAT+2 clocks, identical for every output.
- Reset values: counters 0, pipeline 0, vaddr 0, rgb 0, de 0, frame_start 0, hs/vs = ~SYNC_POL, wx/wy 0.
- First frame after reset: counters run from (0,0) on the first clock after rst falls. frame_start fires RD_LAT+2 clocks later, then once every H_TOTAL·V_TOTAL clocks.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). No partial-line recovery; a full frame restarts.
- win_x/win_y changes between frame starts have no effect until the next (0,0).
- Boundary conditions:
  - win_x ≥ H_ACTIVE: window invisible, all active pixels show bg.
  - win_x = H_ACTIVE-1: one column visible.

## Structure
- Package vga_pkg holds:
  - the timing parameter defaults for the 800x600@72 mode
  - a color_t typedef (COLOR_W bits)
  - the sync-polarity constants
- Sub-module vga_timing_gen contains the counters, raw sync/active decode and the frame-origin strobe. It is reused by later text-mode blocks.
- The top module holds the window registers, address generation, delay pipeline and colour mux.

## Test plan
- Reset release, defaults:
  - hs falls at clock 856+3 after release and rises at 976+3.
  - vs is low for lines 637–642.
  - frame period is 692640 clocks.
- Window at win_x=336, win_y=236, SCALE_LOG2=0, RAM model returns addr[11:0]:
  - pixel (337,237) outputs 12'h081.
  - pixel (335,237) outputs bg_color.
- zero_sub_en=1, zero_color=12'hFFF, RAM returns 0: in-window pixels show FFF. With zero_sub_en=0 they show 000.
- SCALE_LOG2=1, win at (0,0): pixels (0..1, 0..1) all read vaddr 0; pixel (2,0) reads col 1; the window spans 256x256.
- Move win_x mid-frame (line 300): current frame unchanged; the new position appears from the next frame_start.
- Assert rst for 3 clocks at line 400:
  - outputs go to reset values within the cycle.
  - the next frame_start comes RD_LAT+2 clocks after release.
